// File: rtl/spi_master_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the multi-slave SPI master.
//               Holds the transfer state encoding, the four SPI mode
//               constants ({CPOL,CPHA}) and constant-width helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int spi_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a select index that can address num_cs slaves (never 0).
    function automatic int spi_sel_w(input int num_cs);
        return (num_cs > 1) ? spi_clog2(num_cs) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_multi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_gen
// Description : SCK generator for the SPI master. Counts CLK_DIV system
//               cycles per SCK half-period while enabled and toggles SCK at
//               the end of each half-period. lead_o / trail_o are asserted in
//               the cycle before the clock edge on which SCK moves away from /
//               back to its idle level. Disabling forces SCK to idle and
//               restarts the divider.
// Ports       : clk_i   - system clock
//               rst_i   - asynchronous active-high reset
//               en_i    - run the divider (high only while shifting)
//               sck_o   - registered SPI clock level
//               lead_o  - next SCK edge is a leading edge
//               trail_o - next SCK edge is a trailing edge
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 20,
    parameter int CPOL    = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic lead_o,
    output logic trail_o
);

    localparam int                 C_DIV_W    = (CLK_DIV > 1) ? spi_clog2(CLK_DIV) : 1;
    localparam logic               C_IDLE_LVL = (CPOL != 0);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);

    logic [C_DIV_W-1:0] div_q;
    logic               sck_q;
    logic               w_tick;

    assign w_tick  = en_i && (div_q == C_DIV_LAST);
    // While SCK sits at its idle level the coming edge leaves idle (leading).
    assign lead_o  = w_tick && (sck_q == C_IDLE_LVL);
    assign trail_o = w_tick && (sck_q != C_IDLE_LVL);
    assign sck_o   = sck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            sck_q <= C_IDLE_LVL;
        end else if (!en_i) begin
            div_q <= '0;
            sck_q <= C_IDLE_LVL;
        end else if (w_tick) begin
            div_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_multi
// Description : Parametrised full-duplex SPI master with multiple active-low
//               chip selects, all four CPOL/CPHA modes, selectable bit order,
//               programmable CS setup/hold and a START/BUSY/FIN handshake.
// Ports       : SYS_CLK   - system clock, rising edge
//               RST       - asynchronous active-high reset
//               START     - transfer request, honoured only when idle
//               CS_SEL    - slave index, latched with START
//               DATA_MOSI - transmit word, latched with START
//               DATA_MISO - last received word, updated on the FIN cycle
//               BUSY      - transfer in progress (through the FIN cycle)
//               FIN       - one-cycle completion pulse
//               SCK/MOSI  - SPI clock and serial data out
//               MISO      - serial data in (two-flop synchronised)
//               CSbar     - active-low slave selects
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_multi
    import spi_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int NUM_CS    = 2,
    parameter  int CLK_DIV   = 20,
    parameter  int CPOL      = 0,
    parameter  int CPHA      = 0,
    parameter  int MSB_FIRST = 1,
    parameter  int CS_SETUP  = 2,
    parameter  int CS_HOLD   = 2,
    localparam int C_SEL_W   = spi_sel_w(NUM_CS)
) (
    input  logic               SYS_CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [C_SEL_W-1:0] CS_SEL,
    input  logic [WIDTH-1:0]   DATA_MOSI,
    output logic [WIDTH-1:0]   DATA_MISO,
    output logic               BUSY,
    output logic               FIN,
    output logic               SCK,
    output logic               MOSI,
    input  logic               MISO,
    output logic [NUM_CS-1:0]  CSbar
);

    localparam int                  C_CNT_W        = spi_clog2(CS_SETUP + CS_HOLD + 1);
    localparam int                  C_EDGE_W       = spi_clog2(2 * WIDTH + 1);
    localparam logic [C_CNT_W-1:0]  C_SETUP_LAST   = C_CNT_W'(CS_SETUP - 1);
    localparam logic [C_CNT_W-1:0]  C_HOLD_LAST    = C_CNT_W'(CS_HOLD - 1);
    localparam logic [C_EDGE_W-1:0] C_EDGE_LAST    = C_EDGE_W'(2 * WIDTH - 1);
    localparam logic [1:0]          C_MODE         = {CPOL != 0, CPHA != 0};
    localparam bit                  C_SAMPLE_TRAIL = (C_MODE == MODE1) || (C_MODE == MODE3);
    localparam bit                  C_MSB          = (MSB_FIRST != 0);

    spi_state_e          state_q;
    logic [C_CNT_W-1:0]  cnt_q;
    logic [C_EDGE_W-1:0] edge_q;       // SCK edges already issued this frame
    logic [WIDTH-1:0]    tx_q;
    logic [WIDTH-1:0]    tx_d;
    logic [WIDTH-1:0]    rx_q;
    logic [WIDTH-1:0]    rx_d;
    logic [WIDTH-1:0]    data_miso_q;
    logic [1:0]          samp_dly_q;   // sample strobe delayed to match MISO sync
    logic                miso_meta_q;
    logic                miso_sync_q;
    logic                busy_q;
    logic                fin_q;
    logic                mosi_q;
    logic [NUM_CS-1:0]   csbar_q;
    logic [NUM_CS-1:0]   w_cs_n;

    logic w_xfer_en;
    logic w_lead;
    logic w_trail;
    logic w_edge_stb;
    logic w_first_edge;
    logic w_last_edge;
    logic w_sample_stb;
    logic w_shift_stb;

    // ---------------------------------------------------------------- SCK
    assign w_xfer_en = (state_q == ST_XFER);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clk_gen (
        .clk_i   (SYS_CLK),
        .rst_i   (RST),
        .en_i    (w_xfer_en),
        .sck_o   (SCK),
        .lead_o  (w_lead),
        .trail_o (w_trail)
    );

    assign w_edge_stb   = w_lead || w_trail;
    assign w_first_edge = (edge_q == '0);
    assign w_last_edge  = (edge_q == C_EDGE_LAST);
    assign w_sample_stb = C_SAMPLE_TRAIL ? w_trail : w_lead;
    // The first bit is already on MOSI from SETUP, so exactly WIDTH-1 shifts
    // happen: CPHA=1 skips the first leading edge, CPHA=0 skips the final
    // trailing edge so MOSI keeps the last bit after the frame.
    assign w_shift_stb  = C_SAMPLE_TRAIL ? (w_lead && !w_first_edge)
                                         : (w_trail && !w_last_edge);

    // ------------------------------------------------------ chip selects
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
        // Out-of-range indices match no slave, leaving every select high.
        assign w_cs_n[gi] = (CS_SEL != C_SEL_W'(gi));
    end

    // ------------------------------------------------------ shift paths
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (C_MSB) begin
            tx_d = {tx_q[WIDTH-2:0], 1'b0};
        end else begin
            tx_d = {1'b0, tx_q[WIDTH-1:1]};
        end
        if (samp_dly_q[1]) begin
            if (C_MSB) begin
                rx_d = {rx_q[WIDTH-2:0], miso_sync_q};
            end else begin
                rx_d = {miso_sync_q, rx_q[WIDTH-1:1]};
            end
        end
    end

    // --------------------------------------------------- MISO synchroniser
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    // ---------------------------------------------------------- main FSM
    // The synchroniser output seen two cycles after an SCK edge is the MISO
    // level present at that edge, so the sample strobe is delayed to match.
    // DATA_MISO loads rx_d so a sample landing on the HOLD->DONE edge is kept;
    // with CPHA=1 this needs CS_HOLD >= 2 to catch the final bit.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            edge_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            samp_dly_q  <= '0;
            data_miso_q <= '0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            mosi_q      <= 1'b0;
            csbar_q     <= '1;
        end else begin
            fin_q      <= 1'b0;
            rx_q       <= rx_d;
            samp_dly_q <= {samp_dly_q[0], w_sample_stb};

            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        tx_q    <= DATA_MOSI;
                        mosi_q  <= C_MSB ? DATA_MOSI[WIDTH-1] : DATA_MOSI[0];
                        csbar_q <= w_cs_n;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        state_q <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cnt_q == C_SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_XFER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_XFER: begin
                    if (w_edge_stb) begin
                        edge_q <= edge_q + 1'b1;
                        if (w_last_edge) begin
                            state_q <= ST_HOLD;
                        end
                    end
                    if (w_shift_stb) begin
                        tx_q   <= tx_d;
                        mosi_q <= C_MSB ? tx_d[WIDTH-1] : tx_d[0];
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == C_HOLD_LAST) begin
                        cnt_q       <= '0;
                        csbar_q     <= '1;
                        data_miso_q <= rx_d;
                        fin_q       <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    // START is deliberately not looked at here.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign DATA_MISO = data_miso_q;
    assign BUSY      = busy_q;
    assign FIN       = fin_q;
    assign MOSI      = mosi_q;
    assign CSbar     = csbar_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_multi
// Description : Directed self-checking bench for spi_master_multi. Four
//               instances cover mode 0 defaults, mode 3 LSB-first with a
//               slave model, four selects, and CLK_DIV=1 with five selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- u0: defaults, mode 0, loopback
    logic        start0 = 1'b0;
    logic [0:0]  sel0   = '0;
    logic [31:0] dmosi0 = '0;
    logic [31:0] dmiso0;
    logic        busy0, fin0, sck0, mosi0;
    logic [1:0]  csb0;
    int          pulses0 = 0;
    always @(posedge sck0) pulses0++;

    spi_master_multi u0 (
        .SYS_CLK(clk), .RST(rst), .START(start0), .CS_SEL(sel0),
        .DATA_MOSI(dmosi0), .DATA_MISO(dmiso0), .BUSY(busy0), .FIN(fin0),
        .SCK(sck0), .MOSI(mosi0), .MISO(mosi0), .CSbar(csb0)
    );

    // ---------------- u3: mode 3, LSB first, 16 bit, slave model
    logic        start3 = 1'b0;
    logic [0:0]  sel3   = '0;
    logic [15:0] dmosi3 = '0;
    logic [15:0] dmiso3;
    logic        busy3, fin3, sck3, mosi3;
    logic        miso3  = 1'b0;
    logic [1:0]  csb3;
    logic [15:0] slv_tx = 16'hA5C3;
    logic [15:0] slv_rx = '0;
    int          slv_idx = 0;

    spi_master_multi #(
        .WIDTH(16), .CLK_DIV(4), .CPOL(1), .CPHA(1), .MSB_FIRST(0)
    ) u3 (
        .SYS_CLK(clk), .RST(rst), .START(start3), .CS_SEL(sel3),
        .DATA_MOSI(dmosi3), .DATA_MISO(dmiso3), .BUSY(busy3), .FIN(fin3),
        .SCK(sck3), .MOSI(mosi3), .MISO(miso3), .CSbar(csb3)
    );

    // Mode 3 slave on select 1: drive on falling (leading), capture on rising.
    always @(negedge csb3[1]) slv_idx = 0;
    always @(negedge sck3) begin
        if (csb3[1] === 1'b0 && slv_idx < 16) miso3 = slv_tx[slv_idx];
    end
    always @(posedge sck3) begin
        if (csb3[1] === 1'b0 && slv_idx < 16) begin
            slv_rx[slv_idx] = mosi3;
            slv_idx++;
        end
    end

    // ---------------- u4: four selects, 8 bit, CLK_DIV=2, loopback
    logic       start4 = 1'b0;
    logic [1:0] sel4   = '0;
    logic [7:0] dmosi4 = '0;
    logic [7:0] dmiso4;
    logic       busy4, fin4, sck4, mosi4;
    logic [3:0] csb4;

    spi_master_multi #(.WIDTH(8), .NUM_CS(4), .CLK_DIV(2)) u4 (
        .SYS_CLK(clk), .RST(rst), .START(start4), .CS_SEL(sel4),
        .DATA_MOSI(dmosi4), .DATA_MISO(dmiso4), .BUSY(busy4), .FIN(fin4),
        .SCK(sck4), .MOSI(mosi4), .MISO(mosi4), .CSbar(csb4)
    );

    // ---------------- u1: CLK_DIV=1, 8 bit, five selects (3-bit index), loopback
    logic       start1 = 1'b0;
    logic [2:0] sel1   = '0;
    logic [7:0] dmosi1 = '0;
    logic [7:0] dmiso1;
    logic       busy1, fin1, sck1, mosi1;
    logic [4:0] csb1;
    int         pulses1 = 0;
    always @(posedge sck1) pulses1++;

    spi_master_multi #(.WIDTH(8), .NUM_CS(5), .CLK_DIV(1)) u1 (
        .SYS_CLK(clk), .RST(rst), .START(start1), .CS_SEL(sel1),
        .DATA_MOSI(dmosi1), .DATA_MISO(dmiso1), .BUSY(busy1), .FIN(fin1),
        .SCK(sck1), .MOSI(mosi1), .MISO(mosi1), .CSbar(csb1)
    );

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sck0 !== 1'b0 || mosi0 !== 1'b0 || busy0 !== 1'b0 || fin0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_u0_ctrl: got sck=%b mosi=%b busy=%b fin=%b, need 0 0 0 0", sck0, mosi0, busy0, fin0);
        end
        n_checks++;
        if (csb0 !== 2'b11 || dmiso0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_u0_data: got csbar=%b miso_word=%h, need 11 00000000", csb0, dmiso0);
        end
        n_checks++;
        if (sck3 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_u3_sck_idle: got %b need 1", sck3);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n;
        int fins;
        dmosi0 = 32'h1234_5678;
        sel0   = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b1;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            start0 = 1'b0;
        end
        n_checks++;
        if (busy0 !== 1'b1 || csb0 !== 2'b01 || sck0 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_midframe: got busy=%b csbar=%b sck=%b, need 1 01 1", busy0, csb0, sck0);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (csb0 !== 2'b11 || sck0 !== 1'b0 || busy0 !== 1'b0 || fin0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: got csbar=%b sck=%b busy=%b fin=%b, need 11 0 0 0", csb0, sck0, busy0, fin0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        fins = 0;
        repeat (1400) begin
            @(posedge clk); #1;
            if (fin0 === 1'b1) fins++;
        end
        n_checks++;
        if (fins != 0 || dmiso0 !== 32'h0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_fin: got fins=%0d miso_word=%h busy=%b, need 0 00000000 0", fins, dmiso0, busy0);
        end
    endtask

    task automatic test_mode0();
        int n;
        int fin_at;
        dmosi0  = 32'hFAAF_EBBE;
        sel0    = 1'b0;
        pulses0 = 0;
        @(posedge clk); #1;
        start0 = 1'b1;
        n = 0;
        fin_at = 0;
        while (fin_at == 0 && n < 1400) begin
            @(posedge clk); #1;
            n++;
            start0 = 1'b0;
            if (n == 1) begin
                n_checks++;
                if (busy0 !== 1'b1 || csb0 !== 2'b10 || mosi0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL m0_setup: got busy=%b csbar=%b mosi=%b, need 1 10 1", busy0, csb0, mosi0);
                end
            end
            if (n == 700) begin
                n_checks++;
                if (csb0 !== 2'b10) begin
                    n_fail++;
                    $display("FAIL m0_cs_midframe: got %b need 10", csb0);
                end
            end
            if (fin0 === 1'b1) fin_at = n;
        end
        n_checks++;
        if (fin_at != 1285) begin
            n_fail++;
            $display("FAIL m0_latency: got %0d need 1285", fin_at);
        end
        n_checks++;
        if (dmiso0 !== 32'hFAAF_EBBE || pulses0 != 32) begin
            n_fail++;
            $display("FAIL m0_data: got word=%h pulses=%0d, need faafebbe 32", dmiso0, pulses0);
        end
        @(posedge clk); #1;
        n_checks++;
        if (fin0 !== 1'b0 || busy0 !== 1'b0 || csb0 !== 2'b11 || dmiso0 !== 32'hFAAF_EBBE) begin
            n_fail++;
            $display("FAIL m0_after: got fin=%b busy=%b csbar=%b word=%h, need 0 0 11 faafebbe", fin0, busy0, csb0, dmiso0);
        end
    endtask

    task automatic test_mode3_lsb();
        int n;
        int fin_at;
        dmosi3 = 16'h9E69;
        sel3   = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b1;
        n = 0;
        fin_at = 0;
        while (fin_at == 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            start3 = 1'b0;
            if (n == 60) begin
                n_checks++;
                if (csb3 !== 2'b01) begin
                    n_fail++;
                    $display("FAIL m3_cs: got %b need 01", csb3);
                end
            end
            if (fin3 === 1'b1) fin_at = n;
        end
        n_checks++;
        if (fin_at != 133) begin
            n_fail++;
            $display("FAIL m3_latency: got %0d need 133", fin_at);
        end
        n_checks++;
        if (dmiso3 !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL m3_rx: got %h need a5c3", dmiso3);
        end
        n_checks++;
        if (slv_rx !== 16'h9E69) begin
            n_fail++;
            $display("FAIL m3_mosi_stream: got %h need 9e69", slv_rx);
        end
        @(posedge clk); #1;
        n_checks++;
        if (sck3 !== 1'b1 || mosi3 !== 1'b1 || csb3 !== 2'b11) begin
            n_fail++;
            $display("FAIL m3_idle: got sck=%b mosi=%b csbar=%b, need 1 1 11", sck3, mosi3, csb3);
        end
    endtask

    task automatic test_cs_select();
        int n;
        int fin_at;
        dmosi4 = 8'h96;
        sel4   = 2'd2;
        @(posedge clk); #1;
        start4 = 1'b1;
        n = 0;
        fin_at = 0;
        while (fin_at == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            start4 = 1'b0;
            if (n == 10) begin
                n_checks++;
                if (csb4 !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL cs_sel2: got %b need 1011", csb4);
                end
            end
            if (fin4 === 1'b1) fin_at = n;
        end
        n_checks++;
        if (fin_at != 37 || dmiso4 !== 8'h96) begin
            n_fail++;
            $display("FAIL cs_sel2_frame: got fin_at=%0d word=%h, need 37 96", fin_at, dmiso4);
        end
    endtask

    task automatic test_cs_out_of_range();
        int n;
        int fin_at;
        dmosi1 = 8'hC7;
        sel1   = 3'd5;
        @(posedge clk); #1;
        start1 = 1'b1;
        n = 0;
        fin_at = 0;
        while (fin_at == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            start1 = 1'b0;
            if (n == 5) begin
                n_checks++;
                if (csb1 !== 5'b11111) begin
                    n_fail++;
                    $display("FAIL cs_range_high: got %b need 11111", csb1);
                end
            end
            if (fin1 === 1'b1) fin_at = n;
        end
        n_checks++;
        if (fin_at != 21 || dmiso1 !== 8'hC7) begin
            n_fail++;
            $display("FAIL cs_range_frame: got fin_at=%0d word=%h, need 21 c7", fin_at, dmiso1);
        end
    endtask

    task automatic test_clkdiv1();
        int n;
        int fin_at;
        logic [1:0] sck_seen;
        dmosi1  = 8'h3C;
        sel1    = 3'd0;
        pulses1 = 0;
        sck_seen = 2'b00;
        @(posedge clk); #1;
        start1 = 1'b1;
        n = 0;
        fin_at = 0;
        while (fin_at == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            start1 = 1'b0;
            if (n == 4) sck_seen[1] = sck1;
            if (n == 5) sck_seen[0] = sck1;
            if (n == 8) begin
                n_checks++;
                if (csb1 !== 5'b11110) begin
                    n_fail++;
                    $display("FAIL div1_cs: got %b need 11110", csb1);
                end
            end
            if (fin1 === 1'b1) fin_at = n;
        end
        n_checks++;
        if (sck_seen !== 2'b10 || pulses1 != 8) begin
            n_fail++;
            $display("FAIL div1_sck: got levels=%b pulses=%0d, need 10 8", sck_seen, pulses1);
        end
        n_checks++;
        if (fin_at != 21 || dmiso1 !== 8'h3C) begin
            n_fail++;
            $display("FAIL div1_frame: got fin_at=%0d word=%h, need 21 3c", fin_at, dmiso1);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int fin_cnt;
        int fin_first;
        int fin_second;
        int busy_low;
        dmosi1 = 8'h5A;
        sel1   = 3'd1;
        fin_cnt = 0;
        fin_first = 0;
        fin_second = 0;
        busy_low = 0;
        @(posedge clk); #1;
        start1 = 1'b1;
        for (n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if (n <= 43 && busy1 !== 1'b1) busy_low++;
            if (fin1 === 1'b1) begin
                fin_cnt++;
                if (fin_cnt == 1) fin_first = n;
                if (fin_cnt == 2) fin_second = n;
            end
            if (n == 43) start1 = 1'b0;
        end
        n_checks++;
        if (fin_cnt != 2 || fin_first != 21 || fin_second != 43) begin
            n_fail++;
            $display("FAIL b2b_fin: got count=%0d at %0d,%0d, need 2 at 21,43", fin_cnt, fin_first, fin_second);
        end
        n_checks++;
        if (busy_low != 1) begin
            n_fail++;
            $display("FAIL b2b_busy_gap: got %0d low cycles need 1", busy_low);
        end
        n_checks++;
        if (busy1 !== 1'b0 || dmiso1 !== 8'h5A) begin
            n_fail++;
            $display("FAIL b2b_end: got busy=%b word=%h, need 0 5a", busy1, dmiso1);
        end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_mode0();
        test_mode3_lsb();
        test_cs_select();
        test_cs_out_of_range();
        test_clkdiv1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
